// File: rtl/switch_debounce.sv
// switch_debounce: two-flop synchronizer plus a per-channel stability counter for N switch pins.
// Optional SWITCH_DEBOUNCE_EDGE_EN builds registered rise/fall/changed strobes; otherwise they are tied to 0.
module switch_debounce #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_db,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic         changed
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]  sync1_q;
    logic [N-1:0]  sync2_q;
    logic [N-1:0]  db_q;
    logic [N-1:0]  db_d;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // Pure flop-to-flop path so sync1 has a full cycle to resolve metastability.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Each channel is an implicit STABLE/PENDING machine: cnt == 0 with agreement is STABLE,
    // any mismatch counts up, and agreement or acceptance drops it back to zero.
    always_comb begin
        // NOTE: defaults first so no path through the loop leaves a variable unassigned (no latches).
        db_d = db_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q <= '0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is safe to reset.
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db = db_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic [N-1:0] db_last_q;
    logic [N-1:0] rise_q;
    logic [N-1:0] fall_q;
    logic         changed_q;

    // Strobes compare db against its previous value, so they land one edge after sw_db moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_last_q <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            db_last_q <= db_q;
            rise_q    <= db_q & ~db_last_q;
            fall_q    <= ~db_q & db_last_q;
            changed_q <= |(db_q ^ db_last_q);
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign changed = changed_q;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
    assign changed = 1'b0;
`endif

endmodule
